// File: rtl/mux_any_pipe_if.sv
// Bundle of the slice request, buffered result and error-count signals around mux_any_pipe.
// master drives requests and pops; slave is the pipeline itself.
interface mux_any_pipe_if #(
    parameter int A_width   = 8,
    parameter int SEL_width = 2,
    parameter int MUX_width = 2,
    parameter int CNT_width = 8
);
    logic [A_width-1:0]   a;
    logic [SEL_width-1:0] sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [MUX_width-1:0] mux;
    logic                 oor;
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           count;
    logic [CNT_width-1:0] err_cnt;
    logic                 err_clr;

    modport master (
        output a, sel, in_valid, out_ready, err_clr,
        input  in_ready, mux, oor, out_valid, count, err_cnt
    );

    modport slave (
        input  a, sel, in_valid, out_ready, err_clr,
        output in_ready, mux, oor, out_valid, count, err_cnt
    );
endinterface

// File: rtl/mux_any_pipe.sv
// Selects a MUX_width-bit slice of a by index sel and queues it, with an out-of-range flag,
// in a small FIFO; also keeps a saturating count of accepted out-of-range requests.
module mux_any_pipe #(
    parameter int A_width   = 8,
    parameter int SEL_width = 2,
    parameter int MUX_width = 2,
    parameter int DEPTH     = 2,
    parameter int CNT_width = 8
) (
    input logic            clk,
    input logic            rst,
    mux_any_pipe_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = SEL_width + 32;
    localparam int EXT_W = A_width + MUX_width;

    // Reject unusable configurations before anything is built.
    if (A_width < 1 || SEL_width < 1 || MUX_width < 1 || DEPTH < 1 || DEPTH > 16 ||
        CNT_width < 1 || CNT_width > 32) begin : g_bad_params
        $fatal(1, "%m: illegal parameters A_width=%0d SEL_width=%0d MUX_width=%0d DEPTH=%0d CNT_width=%0d",
               A_width, SEL_width, MUX_width, DEPTH, CNT_width);
    end

    typedef struct packed {
        logic                 oor;
        logic [MUX_width-1:0] data;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [4:0]           count;
    logic [CNT_width-1:0] err_cnt;
    logic                 push;
    logic                 pop;
    logic                 sel_unknown;
    logic                 err_hit;
    entry_t               new_entry;
    logic [IDX_W-1:0]     base;
    logic [EXT_W-1:0]     shifted;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The index is widened so sel*MUX_width never wraps; shifting past a's top zero-fills.
    always_comb begin
        sel_unknown    = $isunknown(bus.sel);
        base           = IDX_W'(bus.sel) * IDX_W'(MUX_width);
        shifted        = {{MUX_width{1'b0}}, bus.a} >> base;
        new_entry.data = shifted[MUX_width-1:0];
        new_entry.oor  = (base + IDX_W'(MUX_width)) > IDX_W'(A_width);
        if (sel_unknown) begin
            new_entry.data = 'x;
            new_entry.oor  = 1'bx;
        end
    end

    assign bus.in_ready  = (count < 5'(DEPTH));
    assign bus.out_valid = (count != 5'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign err_hit       = push && !sel_unknown && new_entry.oor;

    assign bus.mux     = bus.out_valid ? mem[rd_ptr].data : '0;
    assign bus.oor     = bus.out_valid ? mem[rd_ptr].oor  : 1'b0;
    assign bus.count   = count;
    assign bus.err_cnt = err_cnt;

    // Storage is deliberately unreset; the output gating above hides stale contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 5'd1;
            end else if (pop && !push) begin
                count <= count - 5'd1;
            end
        end
    end

    // A clear that lands on an out-of-range push still records that push.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (bus.err_clr) begin
            err_cnt <= err_hit ? CNT_width'(1) : '0;
        end else if (err_hit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_any_pipe.sv
// Directed bench for mux_any_pipe with A_width=8, SEL_width=2, MUX_width=3, DEPTH=2, CNT_width=2
// and a fixed data word of 8'hB5.
module tb_mux_any_pipe;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_any_pipe_if #(.A_width(8), .SEL_width(2), .MUX_width(3), .CNT_width(2)) bus ();

    mux_any_pipe #(
        .A_width(8), .SEL_width(2), .MUX_width(3), .DEPTH(2), .CNT_width(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.a = 8'hB5; bus.sel = 2'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.mux !== 3'b000) begin errors++; $display("[TB] FAIL reset_mux: got %b want 000", bus.mux); end
        checks++; if (bus.oor !== 1'b0) begin errors++; $display("[TB] FAIL reset_oor: got %b want 0", bus.oor); end
        checks++; if (bus.err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_single();
        bus.sel = 2'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.mux !== 3'b101) begin errors++; $display("[TB] FAIL single_mux: got %b want 101", bus.mux); end
        checks++; if (bus.oor !== 1'b0) begin errors++; $display("[TB] FAIL single_oor: got %b want 0", bus.oor); end
        checks++; if (bus.count !== 5'd1) begin errors++; $display("[TB] FAIL single_count: got %0d want 1", bus.count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.mux !== 3'b000) begin errors++; $display("[TB] FAIL single_drain_mux: got %b want 000", bus.mux); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.sel = 2'd1; bus.in_valid = 1'b1;
        tick();
        checks++; if (bus.count !== 5'd1) begin errors++; $display("[TB] FAIL bp_count1: got %0d want 1", bus.count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1: got %b want 1", bus.in_ready); end
        bus.sel = 2'd2;
        tick();
        checks++; if (bus.count !== 5'd2) begin errors++; $display("[TB] FAIL bp_count2: got %0d want 2", bus.count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        bus.sel = 2'd3;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== 5'd2) begin errors++; $display("[TB] FAIL bp_full_count: got %0d want 2", bus.count); end
        checks++; if (bus.mux !== 3'b110) begin errors++; $display("[TB] FAIL bp_hold_mux: got %b want 110", bus.mux); end
        checks++; if (bus.oor !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_oor: got %b want 0", bus.oor); end
        checks++; if (bus.err_cnt !== 2'd1) begin errors++; $display("[TB] FAIL bp_err_cnt: got %0d want 1", bus.err_cnt); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.mux !== 3'b010) begin errors++; $display("[TB] FAIL bp_second_mux: got %b want 010", bus.mux); end
        checks++; if (bus.oor !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_oor: got %b want 1", bus.oor); end
        checks++; if (bus.count !== 5'd1) begin errors++; $display("[TB] FAIL bp_second_count: got %0d want 1", bus.count); end
        tick();
        checks++; if (bus.count !== 5'd0) begin errors++; $display("[TB] FAIL bp_empty_count: got %0d want 0", bus.count); end
        checks++; if (bus.err_cnt !== 2'd1) begin errors++; $display("[TB] FAIL bp_final_err: got %0d want 1", bus.err_cnt); end
    endtask

    task automatic test_saturate();
        logic [1:0] want_err [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.sel = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.mux !== 3'b000 || bus.oor !== 1'b1 || bus.out_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL sat_entry%0d: got mux=%b oor=%b valid=%b want 000/1/1", k, bus.mux, bus.oor, bus.out_valid);
            end
            checks++; if (bus.err_cnt !== want_err[k]) begin
                errors++; $display("[TB] FAIL sat_err%0d: got %0d want %0d", k, bus.err_cnt, want_err[k]);
            end
        end
    endtask

    task automatic test_clear();
        bus.sel = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.err_clr = 1'b1;
        tick();
        checks++; if (bus.err_cnt !== 2'd1) begin errors++; $display("[TB] FAIL clr_with_push: got %0d want 1", bus.err_cnt); end
        bus.in_valid = 1'b0;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clr_alone: got %0d want 0", bus.err_cnt); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("[TB] FAIL clr_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_back_to_back();
        bus.sel = 2'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.count !== 5'd1) begin errors++; $display("[TB] FAIL b2b_fill: got %0d want 1", bus.count); end
        bus.sel = 2'd1; bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.count !== 5'd1) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 1", bus.count); end
        checks++; if (bus.mux !== 3'b110 || bus.oor !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_head: got mux=%b oor=%b want 110/0", bus.mux, bus.oor);
        end
        bus.sel = 2'd2; bus.out_ready = 1'b0;
        tick();
        checks++; if (bus.count !== 5'd2) begin errors++; $display("[TB] FAIL b2b_full: got %0d want 2", bus.count); end
        checks++; if (bus.err_cnt !== 2'd1) begin errors++; $display("[TB] FAIL b2b_err: got %0d want 1", bus.err_cnt); end
        rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.err_clr = 1'b0;
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.count !== 5'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL midrst_err: got %0d want 0", bus.err_cnt); end
        checks++; if (bus.mux !== 3'b000 || bus.oor !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_outputs: got mux=%b oor=%b want 000/0", bus.mux, bus.oor);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_saturate();
        test_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
